// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit and its lane aligner.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    // Reserved size 11 is folded in here so the FSM has a single error test.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: isMisaligned = 1'b0;
            SIZE_HALF: isMisaligned = offset[0];
            SIZE_WORD: isMisaligned = (offset != 2'b00);
            default:   isMisaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane extraction (with extension) for loads and lane merge for sub-word stores.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] storeData,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        isSigned,
    output logic [31:0] loadValue,
    output logic [31:0] mergedWord
);

    logic [4:0]  bitBase;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    assign bitBase  = {offset, 3'b000};
    assign laneByte = word[bitBase +: 8];
    assign laneHalf = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        loadValue = word;
        case (size)
            SIZE_BYTE: loadValue = {{24{isSigned & laneByte[7]}}, laneByte};
            SIZE_HALF: loadValue = {{16{isSigned & laneHalf[15]}}, laneHalf};
            default:   loadValue = word;
        endcase
    end

    always_comb begin
        mergedWord = word;
        case (size)
            SIZE_BYTE: mergedWord[bitBase +: 8] = storeData[7:0];
            SIZE_HALF: begin
                if (offset[1]) mergedWord[31:16] = storeData[15:0];
                else           mergedWord[15:0]  = storeData[15:0];
            end
            default:   mergedWord = storeData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store requester for a word-wide RAM; sub-word stores use read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqSigned,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [DATA_WIDTH-1:0] reqData,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_WIDTH-1:0] respData,
    output logic                  respError,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [DATA_WIDTH-1:0] ramDataIn,
    output logic                  ramWriteEnable,
    input  logic [DATA_WIDTH-1:0] ramReadData
);

    logic [2:0]            state, nextState;
    logic [1:0]            sizeQ;
    logic [1:0]            offsetQ;
    logic                  signedQ;
    logic [DATA_WIDTH-1:0] dataQ;
    logic                  accept;
    logic                  reqError;
    logic [DATA_WIDTH-1:0] loadValue;
    logic [DATA_WIDTH-1:0] mergedWord;

    assign accept         = (state == ST_IDLE) && reqValid && reqReady;
    assign reqError       = isMisaligned(reqSize, reqAddr[1:0]);
    assign respValid      = (state == ST_RESP);
    assign ramWriteEnable = (state == ST_WRITE);

    byte_lane_align u_align (
        .word       (ramReadData),
        .storeData  (dataQ),
        .size       (sizeQ),
        .offset     (offsetQ),
        .isSigned   (signedQ),
        .loadValue  (loadValue),
        .mergedWord (mergedWord)
    );

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (reqError)              nextState = ST_RESP;
                    else if (!reqWrite)        nextState = ST_LOAD;
                    else if (reqSize == SIZE_WORD) nextState = ST_WRITE;
                    else                       nextState = ST_READ;
                end
            end
            ST_LOAD:  nextState = ST_RESP;
            ST_READ:  nextState = ST_WRITE;
            ST_WRITE: nextState = ST_RESP;
            ST_RESP:  if (respReady) nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    // reqReady is registered from nextState so it stays low for the first cycle out of reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            reqReady   <= 1'b0;
            sizeQ      <= SIZE_BYTE;
            offsetQ    <= 2'b00;
            signedQ    <= 1'b0;
            dataQ      <= '0;
            respData   <= '0;
            respError  <= 1'b0;
            ramAddress <= '0;
            ramDataIn  <= '0;
        end else begin
            state    <= nextState;
            reqReady <= (nextState == ST_IDLE);
            if (accept) begin
                sizeQ     <= reqSize;
                offsetQ   <= reqAddr[1:0];
                signedQ   <= reqSigned;
                dataQ     <= reqData;
                respData  <= '0;
                respError <= reqError;
                if (!reqError) begin
                    ramAddress <= {2'b00, reqAddr[ADDR_WIDTH-1:2]};
                    if (reqWrite && reqSize == SIZE_WORD)
                        ramDataIn <= reqData;
                end
            end
            if (state == ST_LOAD) respData  <= loadValue;
            if (state == ST_READ) ramDataIn <= mergedWord;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small behavioural word RAM.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqData;
    logic        respValid, respReady, respError;
    logic [31:0] respData;
    logic [31:0] ramAddress, ramDataIn, ramReadData;
    logic        ramWriteEnable;

    logic [31:0] mem [0:15];
    int          errors = 0;
    int          checks = 0;
    int          weCount = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respReady(respReady), .respData(respData), .respError(respError),
        .ramAddress(ramAddress), .ramDataIn(ramDataIn), .ramWriteEnable(ramWriteEnable),
        .ramReadData(ramReadData)
    );

    assign ramReadData = mem[ramAddress[3:0]];
    always @(posedge clk) if (ramWriteEnable) mem[ramAddress[3:0]] <= ramDataIn;
    always @(negedge clk) if (ramWriteEnable) weCount++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!reqReady && n < 50) begin @(negedge clk); n++; end
        if (!reqReady) check("req_ready_timeout", {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d;
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    task automatic waitResp(output int lat, output logic [31:0] rd, output logic re);
        lat = 0; rd = '0; re = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (respValid) break;
            @(posedge clk);
        end
        rd = respData; re = respError;
    endtask

    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       input int expLat, input logic [31:0] expData, input logic expErr,
                       input int expWe);
        int lat; logic [31:0] rd; logic re; int we0;
        respReady = 1'b1;
        we0 = weCount;
        drive(w, sz, sg, a, d);
        waitResp(lat, rd, re);
        check({tag, "_lat"}, lat, expLat);
        check({tag, "_data"}, rd, expData);
        check({tag, "_err"}, {31'b0, re}, {31'b0, expErr});
        @(posedge clk); #1;
        check({tag, "_we"}, weCount - we0, expWe);
    endtask

    initial begin
        int lat; logic [31:0] rd; logic re; int we0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
        reqAddr = '0; reqData = '0; respReady = 1'b1;
        #3;
        check("rst_reqReady", {31'b0, reqReady}, 32'd0);
        check("rst_respValid", {31'b0, respValid}, 32'd0);
        check("rst_respData", respData, 32'd0);
        check("rst_respError", {31'b0, respError}, 32'd0);
        check("rst_we", {31'b0, ramWriteEnable}, 32'd0);
        check("rst_ramAddress", ramAddress, 32'd0);
        check("rst_ramDataIn", ramDataIn, 32'd0);
        @(negedge clk); resetN = 1'b1; #1;
        check("rel_ready_low", {31'b0, reqReady}, 32'd0);
        @(posedge clk); #1;
        check("rel_ready_high", {31'b0, reqReady}, 32'd1);

        txn("sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h15090002, 2, 32'h0, 1'b0, 1);
        check("sw0_mem", mem[0], 32'h15090002);
        txn("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2, 32'h15090002, 1'b0, 0);
        check("lw0_ready_after", {31'b0, reqReady}, 32'd1);

        txn("sb1", 1'b1, 2'b00, 1'b0, 32'h1, 32'h000000AB, 3, 32'h0, 1'b0, 1);
        check("sb1_mem", mem[0], 32'h1509AB02);
        txn("lbs1", 1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 2, 32'hFFFFFFAB, 1'b0, 0);
        txn("lbu1", 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 2, 32'h000000AB, 1'b0, 0);
        txn("lhu2", 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 2, 32'h00001509, 1'b0, 0);
        txn("sh2", 1'b1, 2'b01, 1'b0, 32'h2, 32'hDEAD8001, 3, 32'h0, 1'b0, 1);
        check("sh2_mem", mem[0], 32'h8001AB02);
        txn("lhs2", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 2, 32'hFFFF8001, 1'b0, 0);
        txn("lbu3", 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 2, 32'h00000080, 1'b0, 0);

        txn("lw6", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1, 32'h0, 1'b1, 0);
        txn("lh3", 1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0);
        txn("rsv", 1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, 1, 32'h0, 1'b1, 0);
        check("rsv_mem", mem[0], 32'h8001AB02);

        // Response back-pressure: outputs must hold while respReady is low.
        respReady = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        waitResp(lat, rd, re);
        check("stall_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("stall_valid", {31'b0, respValid}, 32'd1);
            check("stall_data", respData, 32'h8001AB02);
            check("stall_ready", {31'b0, reqReady}, 32'd0);
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        check("stall_ready_after", {31'b0, reqReady}, 32'd1);
        check("stall_valid_after", {31'b0, respValid}, 32'd0);
        txn("lbu0", 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2, 32'h00000002, 1'b0, 0);

        // Reset while a byte store sits in READ.
        txn("sw4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, 2, 32'h0, 1'b0, 1);
        we0 = weCount;
        drive(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000077);
        check("mid_ramAddress", ramAddress, 32'h1);
        #1 resetN = 1'b0;
        #1;
        check("mid_we", {31'b0, ramWriteEnable}, 32'd0);
        check("mid_respValid", {31'b0, respValid}, 32'd0);
        check("mid_reqReady", {31'b0, reqReady}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); resetN = 1'b1; #1;
        check("mid_rel_ready_low", {31'b0, reqReady}, 32'd0);
        @(posedge clk); #1;
        check("mid_rel_ready_high", {31'b0, reqReady}, 32'd1);
        check("mid_respValid2", {31'b0, respValid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_mem", mem[1], 32'h11223344);
        check("mid_we_count", weCount - we0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-side requester that drives the word-wide RAM on behalf of the CPU datapath. It accepts one load/store request at a time over a valid/ready handshake. It converts byte and halfword accesses into word accesses: extract with sign or zero extension on loads, read-modify-write on sub-word stores. It returns each result over a valid/ready response channel and sits between the CPU memory stage and the RAM's address2/readData2/dataIn/writeEnable port.

Parameters:
ADDR_WIDTH, 32, width of byte address from CPU and of ramAddress
DATA_WIDTH, 32, word width; fixed at 32, any other value is unsupported

Ports:
clk  in  1  single clock; all state changes on rising edge
resetN  in  1  asynchronous, active-low reset
reqValid  in  1  request present
reqReady  out  1  unit can accept request this cycle
reqWrite  in  1  1=store, 0=load
reqSize  in  2  00 byte, 01 half, 10 word, 11 reserved
reqSigned  in  1  loads only: 1=sign-extend, 0=zero-extend
reqAddr  in  32  byte address
reqData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
respValid  out  1  response available
respReady  in  1  consumer takes response
respData  out  32  load result; 0 for stores and errors
respError  out  1  misaligned or reserved size
ramAddress  out  32  word index to RAM = reqAddr>>2
ramDataIn  out  32  write word to RAM
ramWriteEnable  out  1  RAM writes ramDataIn at rising edge while high
ramReadData  in  32  RAM read data; combinational from ramAddress

Behaviour:
- Little-endian lanes: byte k = bits [8k+7:8k], k = reqAddr[1:0]; half at addr[1]=1 is bits [31:16].
- Request is latched at a rising edge when reqValid && reqReady. All later datapath uses the latched copy.
- States: IDLE, LOAD, READ, WRITE, RESP.
- IDLE: reqReady=1. On accept:
  - error (half with addr[0]=1, word with addr[1:0]!=0, or size 11) -> RESP, respError=1, no RAM access;
  - load -> LOAD;
  - word store -> WRITE;
  - byte/half store -> READ.
- LOAD: ramAddress driven. At next edge, the extracted and extended lane is captured into respData -> RESP.
- READ: ramAddress driven. At next edge, ramReadData is merged with the store lane into a write register -> WRITE.
- WRITE: ramWriteEnable=1 for exactly this one cycle; ramDataIn = merged word, or reqData for word stores. Next edge -> RESP.
- RESP: respValid=1; respData and respError are held stable until the edge where respReady=1, then -> IDLE.
- reqReady=0 in every state except IDLE. A request is never accepted in the same cycle a response completes.
- Latency, accept edge to respValid high:
  - load: 2 edges;
  - word store: 2 edges;
  - sub-word store: 3 edges;
  - error: 1 edge.
- ramWriteEnable is 0 in all states except WRITE. ramAddress and ramDataIn hold their last values when idle.
- Reset, asynchronous and taking effect mid-operation:
  - state=IDLE; any in-flight request is dropped with no response and no RAM write; ramWriteEnable drops immediately.
  - Output reset values: reqReady=0, respValid=0, respData=0, respError=0, ramWriteEnable=0, ramAddress=0, ramDataIn=0.
  - reqReady is a registered output and rises at the first rising edge after resetN deasserts.

Decomposition:
- Package lsu_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encoding for IDLE/LOAD/READ/WRITE/RESP;
  - function isMisaligned(size, addr[1:0]).
- Sub-module byte_lane_align, purely combinational:
  - extract(word, size, offset, signed) -> 32-bit load value;
  - merge(oldWord, storeData, size, offset) -> 32-bit write word.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Word store 0x15090002 to addr 0, then word load addr 0 -> RAM word 0 = 0x15090002; ramWriteEnable high exactly one cycle; load respData=0x15090002, respError=0, respValid 2 edges after accept.
- Byte store 0xAB to addr 1 over 0x15090002 -> READ then WRITE, RAM word 0x1509AB02, respValid 3 edges after accept. Signed byte load addr 1 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half load addr 2 unsigned on 0x1509AB02 -> 0x00001509. Half store 0x8001 to addr 2 -> word 0x8001AB02. Signed half load addr 2 -> 0xFFFF8001.
- Word load addr 0x6, and half load addr 0x3 -> respError=1, respData=0, respValid 1 edge after accept, ramWriteEnable never asserted.
- respReady held low 5 cycles after load response -> respValid and respData stable, reqReady=0 throughout. reqReady=1 in the cycle after the handshake edge, and the next request is accepted.
- resetN pulled low during READ of a byte store -> ramWriteEnable=0 and respValid=0 immediately, RAM word unchanged, reqReady=0 until the first edge after release.
